conv_window_feeder: RTL
=======================

# conv_window_feeder

Source side of the CONV load interface. Accepts 9 serial weights, then a raster-order pixel stream. Builds 3x3 sliding windows through two line buffers. Drives the parallel weight bus with a `w_w` strobe and each window with an `if_w` strobe, so the convolution core computes one dot product per valid window position.

## Interface
Parameters:
- `DATA_W`, default `` `Pixel_DataSize `` (8): signed pixel/weight width.
- `IMG_W`, default 8: image width in pixels, minimum 3.
- `IMG_H`, default 8: image height in pixels, minimum 3.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a frame; sampled in IDLE only.
- `wt_valid` in 1: serial weight strobe.
- `wt_in` in DATA_W: signed weight; order w0..w8, row-major.
- `pix_valid` in 1: pixel strobe.
- `pix_in` in DATA_W: signed pixel; raster order.
- `pix_ready` out 1: pixel accepted when `pix_valid & pix_ready`.
- `w_w` out 1: one-cycle weight-bus load strobe.
- `w_out0..w_out8` out DATA_W each: weight bus.
- `if_w` out 1: one-cycle window load strobe.
- `if_out0..if_out8` out DATA_W each: window bus.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle end-of-frame pulse.

## Operation
- States: IDLE, LOAD_W, STREAM, DONE.
  - IDLE -> LOAD_W on `start`.
  - LOAD_W -> STREAM after the 9th accepted weight.
  - STREAM -> DONE after the final window is emitted.
  - DONE -> IDLE unconditionally.
- LOAD_W:
  - Each `wt_valid` cycle stores `wt_in` into slot k, k = 0..8.
  - `wt_valid` in any other state is ignored.
- `w_w` is high for exactly one cycle: the cycle after the 9th weight is accepted, coincident with entry to STREAM.
- `w_out*` hold their values until the next frame's load completes.
- `pix_ready` is 1 in STREAM only. The downstream consumer never stalls, so there is no backpressure.
- Column counter c runs 0..IMG_W-1; row counter r runs 0..IMG_H-1. Both advance on each accepted pixel; c wraps to 0 and increments r.
- Two IMG_W-deep line buffers hold rows r-1 and r-2. A 3x3 shift window takes three taps per accepted pixel.
- Valid window: the pixel accepted at (r,c) has r>=2 and c>=2. Window mapping, row-major:
  - `if_out0` = p(r-2,c-2)
  - `if_out4` = p(r-1,c-1)
  - `if_out8` = p(r,c)
- No zero padding. A frame emits (IMG_H-2)*(IMG_W-2) windows.
- `if_out*` hold their values between `if_w` pulses.
- Arithmetic: none. Values are pure data movement; sign is preserved with no truncation.
- Boundary conditions:
  - `start` while `busy` is ignored.
  - Pixels past the last one in a frame are not accepted, because `pix_ready` drops in DONE.
  - Row wrap: pixels at c<2 never produce windows, including at the wrap into the next row.
  - `rst` mid-frame returns to IDLE and zeroes all outputs. Line buffer contents need not be cleared; the counters gate window validity.

## Timing
- Reset values:
  - All outputs are 0, including `w_out*`, `if_out*`, `w_w`, `if_w`, `pix_ready`, `busy` and `done`.
  - State is IDLE and all counters are 0.
- `start` sampled at edge t -> `busy` = 1 from cycle t+1.
- Weight latency: 9th weight accepted in cycle t -> `w_w` = 1 in cycle t+1.
- Window latency: pixel (r,c) accepted in cycle t -> `if_w` = 1 with that window in cycle t+1. With back-to-back pixels, `if_w` can be high in consecutive cycles.
- Final pixel (IMG_H-1, IMG_W-1) accepted in cycle t:
  - cycle t+1: last `if_w`, state DONE.
  - cycle t+2: `done` = 1.
  - cycle t+3: IDLE, `busy` = 0.

## Configuration
- `CONV_FEEDER_STRIDE2_EN`, defined: a window is emitted only if (r-2) and (c-2) are both even. All pixels are still accepted and shifted.
  - Window count is ceil((IMG_H-2)/2) * ceil((IMG_W-2)/2).
  - The `done` cycle relation to the final pixel is unchanged.
- Undefined: stride 1, as described above.

## Structure
- Shared header `conv_defs.vh`: `Pixel_DataSize` and the feeder state encodings (IDLE=0, LOAD_W=1, STREAM=2, DONE=3).
- Sub-module `conv_line_buffer`: DATA_W-wide, IMG_W-deep shift register with shift enable. Instantiated twice (row r-1 and row r-2).

## Test plan
- Reset check: hold `rst` during activity -> all outputs 0, `busy` = 0; then `start` -> `busy` = 1 the next cycle.
- Weight load (IMG_W = IMG_H = 4):
  - Stimulus: `start`, then weights 1..9 on consecutive cycles.
  - Required: single `w_w` pulse one cycle after weight 9, with `w_out0` = 1 … `w_out8` = 9.
- Frame (IMG_W = IMG_H = 4), pixels 0..15 streamed back-to-back:
  - Exactly 4 `if_w` pulses.
  - First window is 0,1,2,4,5,6,8,9,10; second window is each value +1.
  - The attached CONV outputs 303 and 348.
  - `done` follows two cycles after pixel 15.
- Gapped stream: random `pix_valid` gaps -> same 4 windows in the same order; `if_w` count is unchanged.
- Negative data: weights -128, 127 and pixels -1, -128 -> values pass bit-exact to `w_out*` and `if_out*`.
- Mid-frame reset then restart:
  - Assert `rst` after pixel 9, then run a full new frame.
  - Required: no stale window emitted; output is identical to a clean frame.
- With `CONV_FEEDER_STRIDE2_EN` at 6x6 -> 4 windows, at top-left origins (0,0), (0,2), (2,0), (2,2).

Source files
------------

// File: rtl/conv_window_feeder_pkg.sv
// Shared definitions for the CONV window feeder: default pixel width and FSM state encodings.
package conv_window_feeder_pkg;

    localparam int PIXEL_DATA_SIZE = 8;
    localparam int NUM_TAPS        = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } feeder_state_e;

endpackage

// File: rtl/conv_window_feeder_line_buffer.sv
// One image row of delay: a DEPTH-deep shift register advanced only on accepted pixels.
module conv_line_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              shift_en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (shift_en) mem_d = {mem_q[DEPTH-2:0], din};
    end

    // Contents are never cleared; frame counters decide when taps are meaningful.
    always_ff @(posedge clk) mem_q <= mem_d;

    assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/conv_window_feeder.sv
// Serial weight loader plus 3x3 sliding-window builder for the CONV core.
// Build option: CONV_FEEDER_STRIDE2_EN emits only windows whose top-left origin is on even row/col.
module conv_window_feeder
    import conv_window_feeder_pkg::*;
#(
    parameter int DATA_W = PIXEL_DATA_SIZE,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              wt_valid,
    input  logic [DATA_W-1:0] wt_in,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_in,
    output logic              pix_ready,
    output logic              w_w,
    output logic [DATA_W-1:0] w_out0,
    output logic [DATA_W-1:0] w_out1,
    output logic [DATA_W-1:0] w_out2,
    output logic [DATA_W-1:0] w_out3,
    output logic [DATA_W-1:0] w_out4,
    output logic [DATA_W-1:0] w_out5,
    output logic [DATA_W-1:0] w_out6,
    output logic [DATA_W-1:0] w_out7,
    output logic [DATA_W-1:0] w_out8,
    output logic              if_w,
    output logic [DATA_W-1:0] if_out0,
    output logic [DATA_W-1:0] if_out1,
    output logic [DATA_W-1:0] if_out2,
    output logic [DATA_W-1:0] if_out3,
    output logic [DATA_W-1:0] if_out4,
    output logic [DATA_W-1:0] if_out5,
    output logic [DATA_W-1:0] if_out6,
    output logic [DATA_W-1:0] if_out7,
    output logic [DATA_W-1:0] if_out8,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    feeder_state_e state_q, state_d;
    logic [3:0]                      wcnt_q, wcnt_d;
    logic [7:0][DATA_W-1:0]          wshadow_q, wshadow_d;
    logic [NUM_TAPS-1:0][DATA_W-1:0] w_out_q, w_out_d;
    logic                            w_w_q, w_w_d;
    logic [CW-1:0]                   col_q, col_d;
    logic [RW-1:0]                   row_q, row_d;
    logic [2:0][1:0][DATA_W-1:0]     hist_q, hist_d;
    logic [NUM_TAPS-1:0][DATA_W-1:0] if_out_q, if_out_d;
    logic                            if_w_q, if_w_d;
    logic                            done_q, done_d;
    logic                            busy_q, busy_d;

    logic                            pix_acc;
    logic                            win_valid;
    logic                            last_pix;
    logic [1:0][DATA_W-1:0]          lb_in, lb_out;
    logic [2:0][DATA_W-1:0]          tap;
    logic [NUM_TAPS-1:0][DATA_W-1:0] win;

    assign pix_acc = pix_valid && (state_q == STREAM);

    // Cascade: buffer 0 delays by one row (r-1), buffer 1 by two rows (r-2).
    assign lb_in = {lb_out[0], pix_in};

    for (genvar g = 0; g < 2; g++) begin : g_lb
        conv_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb (
            .clk      (clk),
            .shift_en (pix_acc),
            .din      (lb_in[g]),
            .dout     (lb_out[g])
        );
    end

    assign tap = {pix_in, lb_out[0], lb_out[1]};
    assign win = {tap[2], hist_q[2][1], hist_q[2][0],
                  tap[1], hist_q[1][1], hist_q[1][0],
                  tap[0], hist_q[0][1], hist_q[0][0]};

    assign last_pix = (col_q == COL_LAST) && (row_q == ROW_LAST);

`ifdef CONV_FEEDER_STRIDE2_EN
    assign win_valid = (row_q >= ROW_TWO) && (col_q >= COL_TWO) && !row_q[0] && !col_q[0];
`else
    assign win_valid = (row_q >= ROW_TWO) && (col_q >= COL_TWO);
`endif

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        wshadow_d = wshadow_q;
        w_out_d   = w_out_q;
        w_w_d     = 1'b0;
        col_d     = col_q;
        row_d     = row_q;
        hist_d    = hist_q;
        if_out_d  = if_out_q;
        if_w_d    = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !busy_q) begin
                    state_d = LOAD_W;
                    wcnt_d  = '0;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            LOAD_W: begin
                if (wt_valid) begin
                    if (wcnt_q == 4'd8) begin
                        w_out_d = {wt_in, wshadow_q};
                        w_w_d   = 1'b1;
                        wcnt_d  = '0;
                        state_d = STREAM;
                    end else begin
                        wshadow_d[wcnt_q[2:0]] = wt_in;
                        wcnt_d = wcnt_q + 4'd1;
                    end
                end
            end
            STREAM: begin
                if (pix_acc) begin
                    hist_d = {tap[2], hist_q[2][1], tap[1], hist_q[1][1], tap[0], hist_q[0][1]};
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if (win_valid) begin
                        if_out_d = win;
                        if_w_d   = 1'b1;
                    end
                    if (last_pix) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // busy also covers the done cycle, which lands after the FSM is already back in IDLE.
    assign busy_d = (state_d != IDLE) || (state_q == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            wshadow_q <= '0;
            w_out_q   <= '0;
            w_w_q     <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            hist_q    <= '0;
            if_out_q  <= '0;
            if_w_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            wshadow_q <= wshadow_d;
            w_out_q   <= w_out_d;
            w_w_q     <= w_w_d;
            col_q     <= col_d;
            row_q     <= row_d;
            hist_q    <= hist_d;
            if_out_q  <= if_out_d;
            if_w_q    <= if_w_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign pix_ready = (state_q == STREAM);
    assign w_w       = w_w_q;
    assign if_w      = if_w_q;
    assign busy      = busy_q;
    assign done      = done_q;

    assign w_out0 = w_out_q[0];
    assign w_out1 = w_out_q[1];
    assign w_out2 = w_out_q[2];
    assign w_out3 = w_out_q[3];
    assign w_out4 = w_out_q[4];
    assign w_out5 = w_out_q[5];
    assign w_out6 = w_out_q[6];
    assign w_out7 = w_out_q[7];
    assign w_out8 = w_out_q[8];

    assign if_out0 = if_out_q[0];
    assign if_out1 = if_out_q[1];
    assign if_out2 = if_out_q[2];
    assign if_out3 = if_out_q[3];
    assign if_out4 = if_out_q[4];
    assign if_out5 = if_out_q[5];
    assign if_out6 = if_out_q[6];
    assign if_out7 = if_out_q[7];
    assign if_out8 = if_out_q[8];

endmodule
